// File: rtl/fpu_cvt_writeback.sv
// fpu_cvt_writeback: writeback stage behind the FP32 conversion unit.
// Each conversion result is formatted for its register file and queued in a small in-order FIFO.
// The head entry is offered to the commit arbiter with a valid/ready handshake.
// The exception flags of each committed entry are accumulated into the sticky fflags register.
// Optional build macro CVT_WB_BYPASS_EN adds a zero-latency path from the input to the output.
// That path is used only when the FIFO is empty.
module fpu_cvt_writeback #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [63:0]               in_result,
  input  logic [1:0]                in_output_type,
  input  logic [RD_W-1:0]           in_rd,
  input  logic                      in_flag_invalid,
  input  logic                      in_flag_overflow,
  input  logic                      in_flag_underflow,
  input  logic                      in_flag_inexact,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_is_fp,
  output logic [RD_W-1:0]           out_rd,
  output logic [63:0]               out_data,
  input  logic                      flush,
  input  logic                      csr_we,
  input  logic [4:0]                csr_wdata,
  output logic [4:0]                fflags,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    OT_FP32   = 2'b00,
    OT_FP64   = 2'b01,
    OT_INT32  = 2'b10,
    OT_UINT32 = 2'b11
  } out_type_e;

  typedef struct packed {
    logic [63:0]     data;
    logic [RD_W-1:0] rd;
    logic            is_fp;
    logic [4:0]      flags;   // {NV, DZ(always 0), OF, UF, NX}
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head;
  out_type_e       in_type;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic            fifo_valid;
  logic            enq;
  logic            deq;
  logic            deq_fifo;
  logic [4:0]      commit_flags;

  assign in_type    = out_type_e'(in_output_type);
  assign fifo_valid = (count != '0);
  // Ready depends only on occupancy, so there is no combinational path from out_ready to in_ready.
  assign in_ready   = (count != FULL);

  // Format the incoming result into a register-file-ready entry.
  always_comb begin
    // NOTE: every field gets a default first so no path through the case leaves a latch behind.
    in_entry       = '0;
    in_entry.rd    = in_rd;
    in_entry.flags = {in_flag_invalid, 1'b0, in_flag_overflow, in_flag_underflow, in_flag_inexact};
    case (in_type)
      OT_FP64: begin
        in_entry.data  = in_result;
        in_entry.is_fp = 1'b1;
      end
      OT_FP32: begin
        in_entry.data  = {32'hFFFF_FFFF, in_result[31:0]};
        in_entry.is_fp = 1'b1;
      end
      // UINT32 is sign-extended like INT32, which matches the RV64 convention for 32-bit results.
      default: begin
        in_entry.data  = {{32{in_result[31]}}, in_result[31:0]};
        in_entry.is_fp = 1'b0;
      end
    endcase
  end

  // Select what is presented to the commit stage and decide enqueue/dequeue.
  always_comb begin
`ifdef CVT_WB_BYPASS_EN
    if (fifo_valid)    head = mem[rd_ptr];
    else if (in_valid) head = in_entry;
    else               head = '0;
    out_valid = fifo_valid || in_valid;
    // An entry that is consumed straight through the bypass is never written into the FIFO.
    enq       = in_valid && in_ready && !flush && !(!fifo_valid && out_ready);
`else
    head      = fifo_valid ? mem[rd_ptr] : '0;
    out_valid = fifo_valid;
    enq       = in_valid && in_ready && !flush;
`endif
    deq          = out_valid && out_ready;
    deq_fifo     = deq && fifo_valid;
    commit_flags = deq ? head.flags : 5'b0;
  end

  assign out_data  = head.data;
  assign out_rd    = head.rd;
  assign out_is_fp = head.is_fp;

  // Advance the pointers and the occupancy; a flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq_fifo})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Write the formatted entry into FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only visible through the head mux once count covers it.
    if (enq) mem[wr_ptr] <= in_entry;
  end

  // Sticky flags: a software write replaces the old value, and committed flags are always ORed in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fflags <= 5'b0;
    else        fflags <= (csr_we ? csr_wdata : fflags) | commit_flags;
  end

endmodule

// File: tb/tb_fpu_cvt_writeback.sv
// tb_fpu_cvt_writeback: directed self-checking bench for fpu_cvt_writeback (DEPTH=4, RD_W=5).
module tb_fpu_cvt_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [1:0]  in_output_type;
  logic [4:0]  in_rd;
  logic        in_flag_invalid, in_flag_overflow, in_flag_underflow, in_flag_inexact;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_fp;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic        flush;
  logic        csr_we;
  logic [4:0]  csr_wdata;
  logic [4:0]  fflags;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus table for the fill/stream test, with hand-computed formatted values.
  logic [63:0] t_res  [12];
  logic [1:0]  t_type [12];
  logic [63:0] t_exp  [12];
  logic        t_fp   [12];
  int          q[$];
  int          p;

  fpu_cvt_writeback #(.DEPTH(4), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_output_type(in_output_type), .in_rd(in_rd),
    .in_flag_invalid(in_flag_invalid), .in_flag_overflow(in_flag_overflow),
    .in_flag_underflow(in_flag_underflow), .in_flag_inexact(in_flag_inexact),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_fp(out_is_fp),
    .out_rd(out_rd), .out_data(out_data),
    .flush(flush), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .fflags(fflags), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fl = {NV, OF, UF, NX}
  task automatic drive(input logic v, input logic [63:0] res, input logic [1:0] ty,
                       input logic [4:0] rd, input logic [3:0] fl);
    in_valid          = v;
    in_result         = res;
    in_output_type    = ty;
    in_rd             = rd;
    in_flag_invalid   = fl[3];
    in_flag_overflow  = fl[2];
    in_flag_underflow = fl[1];
    in_flag_inexact   = fl[0];
  endtask

  // One cycle of the fill/stream test against a queue model of the FIFO.
  task automatic stream_step();
    logic full_m, deq_m, acc_m;
    if (p < 12) drive(1'b1, t_res[p], t_type[p], 5'(p), 4'b0000);
    else        drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("stream_count", 64'(count), 64'(q.size()));
    check("stream_in_ready", 64'(in_ready), 64'(q.size() != 4));
    check("stream_out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("stream_data", out_data, t_exp[q[0]]);
      check("stream_rd", 64'(out_rd), 64'(q[0]));
      check("stream_is_fp", 64'(out_is_fp), 64'(t_fp[q[0]]));
    end
    full_m = (q.size() == 4);
    deq_m  = out_ready && (q.size() != 0);
    acc_m  = (p < 12) && !full_m;
    if (deq_m) void'(q.pop_front());
    if (acc_m) begin
      q.push_back(p);
      p++;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    t_res[0] = 64'h400921FB_54442D18; t_type[0] = 2'b01; t_exp[0] = 64'h400921FB_54442D18; t_fp[0] = 1'b1;
    t_res[1] = 64'hABCD0000_7FFFFFFF; t_type[1] = 2'b10; t_exp[1] = 64'h00000000_7FFFFFFF; t_fp[1] = 1'b0;
    t_res[2] = 64'h00000000_FFFFFFFE; t_type[2] = 2'b11; t_exp[2] = 64'hFFFFFFFF_FFFFFFFE; t_fp[2] = 1'b0;
    t_res[3] = 64'h5555AAAA_C0490FDB; t_type[3] = 2'b00; t_exp[3] = 64'hFFFFFFFF_C0490FDB; t_fp[3] = 1'b1;
    for (int k = 4; k < 12; k++) begin
      t_res[k]  = 64'hC0DE0000_00000000 + 64'(k);
      t_type[k] = 2'b01;
      t_exp[k]  = 64'hC0DE0000_00000000 + 64'(k);
      t_fp[k]   = 1'b1;
    end

    rst_n = 1'b0;
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    out_ready = 1'b0; flush = 1'b0; csr_we = 1'b0; csr_wdata = 5'b0;
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_is_fp", 64'(out_is_fp), 64'd0);
    check("rst_fflags", 64'(fflags), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // INT32 with bit 31 set, NX raised.
    drive(1'b1, 64'h00000000_80000000, 2'b10, 5'd3, 4'b0001);
    out_ready = 1'b1;
    #1;
    check("int_latency", 64'(out_valid), 64'd0);
    tick();
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("int_out_valid", 64'(out_valid), 64'd1);
    check("int_data", out_data, 64'hFFFFFFFF_80000000);
    check("int_is_fp", 64'(out_is_fp), 64'd0);
    check("int_rd", 64'(out_rd), 64'd3);
    check("int_no_flag_on_enq", 64'(fflags), 64'd0);
    tick();
    #1;
    check("int_fflags", 64'(fflags), 64'b00001);
    check("int_count", 64'(count), 64'd0);

    // FP32 is NaN-boxed; held while out_ready is low.
    out_ready = 1'b0;
    drive(1'b1, 64'h12345678_3F800000, 2'b00, 5'd7, 4'b0000);
    tick();
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("fp32_data", out_data, 64'hFFFFFFFF_3F800000);
    check("fp32_is_fp", 64'(out_is_fp), 64'd1);
    tick();
    check("fp32_hold_data", out_data, 64'hFFFFFFFF_3F800000);
    check("fp32_hold_rd", 64'(out_rd), 64'd7);
    out_ready = 1'b1;
    tick();
    #1;
    check("fp32_drained", 64'(count), 64'd0);

    // Fill with out_ready low (5th push refused), then stream through the pointer wrap.
    p = 0;
    q.delete();
    out_ready = 1'b0;
    for (int it = 0; it < 5; it++) stream_step();
    out_ready = 1'b1;
    for (int it = 0; it < 16; it++) stream_step();
    check("stream_all_pushed", 64'(p), 64'd12);
    check("stream_fflags", 64'(fflags), 64'b00001);

    // CSR write and commit in the same cycle.
    csr_we = 1'b1; csr_wdata = 5'b10000;
    out_ready = 1'b0;
    drive(1'b1, 64'h00000000_00000001, 2'b10, 5'd9, 4'b0100);
    tick();
    csr_we = 1'b0;
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("csr_set", 64'(fflags), 64'b10000);
    out_ready = 1'b1; csr_we = 1'b1; csr_wdata = 5'b00000;
    tick();
    csr_we = 1'b0;
    #1;
    check("csr_and_commit", 64'(fflags), 64'b00100);
    check("csr_count", 64'(count), 64'd0);

    // Flush with a concurrent enqueue and dequeue.
    out_ready = 1'b0; csr_we = 1'b1; csr_wdata = 5'b0;
    drive(1'b1, 64'h11, 2'b01, 5'd1, 4'b0010);
    tick();
    csr_we = 1'b0;
    drive(1'b1, 64'h22, 2'b01, 5'd2, 4'b0001);
    tick();
    drive(1'b1, 64'h33, 2'b01, 5'd3, 4'b1000);
    tick();
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("flush_pre_count", 64'(count), 64'd3);
    check("flush_pre_fflags", 64'(fflags), 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 64'h44, 2'b01, 5'd4, 4'b0100);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_fflags", 64'(fflags), 64'b00010);
    tick();
    check("flush_enq_dropped", 64'(count), 64'd0);

    // Empty FIFO, FP64 entry with out_ready high.
    out_ready = 1'b1;
    drive(1'b1, 64'h3FF00000_00000000, 2'b01, 5'd12, 4'b0000);
    #1;
`ifdef CVT_WB_BYPASS_EN
    check("byp_out_valid", 64'(out_valid), 64'd1);
    check("byp_data", out_data, 64'h3FF00000_00000000);
    check("byp_is_fp", 64'(out_is_fp), 64'd1);
    tick();
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("byp_count", 64'(count), 64'd0);
    check("byp_out_valid_after", 64'(out_valid), 64'd0);
`else
    check("nobyp_out_valid", 64'(out_valid), 64'd0);
    tick();
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("nobyp_out_valid_next", 64'(out_valid), 64'd1);
    check("nobyp_data", out_data, 64'h3FF00000_00000000);
    check("nobyp_is_fp", 64'(out_is_fp), 64'd1);
    tick();
    check("nobyp_count", 64'(count), 64'd0);
`endif

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    drive(1'b1, 64'h55, 2'b10, 5'd5, 4'b1000);
    tick();
    drive(1'b0, 64'h0, 2'b00, 5'd0, 4'b0000);
    #1;
    check("midrst_pre_count", 64'(count), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_fflags", 64'(fflags), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
